// File: rtl/gcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gcd_pkg : shared state encoding and datapath mux-select patterns     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package gcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_ITER   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // Subtractor operand selects, packed as {sel1, sel2}
    localparam logic [1:0] c_SUB_A_MINUS_B = 2'b01;
    localparam logic [1:0] c_SUB_B_MINUS_A = 2'b10;
    localparam logic       c_SEL_DATA_IN   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin grant with registered pointer |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W:0]   w_idx;

    // Walk from the farthest candidate back to ptr+1 so the nearest one wins
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        w_idx       = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            w_idx = {1'b0, r_ptr} + (ID_W+1)'(off);
            if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(NUM_REQ);
            end
            if (req[w_idx[ID_W-1:0]]) begin
                grant                    = '0;
                grant[w_idx[ID_W-1:0]]   = 1'b1;
                grant_id                 = w_idx[ID_W-1:0];
                grant_valid              = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= ID_W'(NUM_REQ - 1);
        end else if (en && grant_valid) begin
            r_ptr <= grant_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gcd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gcd_sched : round-robin scheduler sharing one GCD datapath between   |
// |             NUM_REQ requesters, with id-tagged responses             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module gcd_sched
    import gcd_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int W        = 16,
    parameter int ID_W     = 2,
    parameter int MAX_ITER = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [W-1:0]         rsp_gcd,
    output logic                 rsp_err,
    output logic [W-1:0]         dp_data_in,
    output logic                 dp_ldA,
    output logic                 dp_ldB,
    output logic                 dp_sel1,
    output logic                 dp_sel2,
    output logic                 dp_selin,
    input  logic                 dp_lt,
    input  logic                 dp_gt,
    input  logic                 dp_eq,
    input  logic [W-1:0]         dp_aout
);

    localparam int              CNT_W        = $clog2(MAX_ITER + 1);
    localparam logic [CNT_W-1:0] c_MAX_ITER  = CNT_W'(MAX_ITER);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    state_t             r_state;
    logic [W-1:0]       r_op_a;
    logic [W-1:0]       r_op_b;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_gid;
    logic               w_gvalid;
    logic               w_idle;
    logic               w_cnt_max;
    logic [W-1:0]       w_gnt_a;
    logic [W-1:0]       w_gnt_b;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_cnt_max = (r_cnt == c_MAX_ITER);
    assign req_ready = (rst_n && w_idle) ? w_grant : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_valid),
        .en          (w_idle),
        .grant       (w_grant),
        .grant_id    (w_gid),
        .grant_valid (w_gvalid)
    );

    always_comb begin
        w_gnt_a = '0;
        w_gnt_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_a = req_a[i*W +: W];
                w_gnt_b = req_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_cnt     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_gcd   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gvalid) begin
                        r_op_a <= w_gnt_a;
                        r_op_b <= w_gnt_b;
                        rsp_id <= w_gid;
                        // A zero operand would never reach eq in the datapath
                        if (w_gnt_a == '0 || w_gnt_b == '0) begin
                            rsp_gcd   <= w_gnt_a | w_gnt_b;
                            rsp_err   <= 1'b0;
                            rsp_valid <= 1'b1;
                            r_state   <= ST_RESP;
                        end else begin
                            r_state <= ST_LOAD_A;
                        end
                    end
                end
                ST_LOAD_A: r_state <= ST_LOAD_B;
                ST_LOAD_B: begin
                    r_cnt   <= '0;
                    r_state <= ST_ITER;
                end
                ST_ITER: begin
                    if (dp_eq) begin
                        rsp_gcd   <= dp_aout;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        r_state   <= ST_RESP;
                    end else if (w_cnt_max) begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        r_state   <= ST_RESP;
                    end else if (dp_gt || dp_lt) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dp_data_in = '0;
        dp_ldA     = 1'b0;
        dp_ldB     = 1'b0;
        dp_sel1    = 1'b0;
        dp_sel2    = 1'b0;
        dp_selin   = 1'b0;
        case (r_state)
            ST_LOAD_A: begin
                dp_data_in = r_op_a;
                dp_selin   = c_SEL_DATA_IN;
                dp_ldA     = 1'b1;
            end
            ST_LOAD_B: begin
                dp_data_in = r_op_b;
                dp_selin   = c_SEL_DATA_IN;
                dp_ldB     = 1'b1;
            end
            ST_ITER: begin
                // No subtraction on the cycle that reports the result or the limit
                if (!dp_eq && !w_cnt_max) begin
                    if (dp_gt) begin
                        {dp_sel1, dp_sel2} = c_SUB_A_MINUS_B;
                        dp_ldA             = 1'b1;
                    end else if (dp_lt) begin
                        {dp_sel1, dp_sel2} = c_SUB_B_MINUS_A;
                        dp_ldB             = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gcd_sched : randomized and directed bench with a behavioural GCD  |
// |                reference model and a simple datapath model           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_gcd_sched;

    localparam int NUM_REQ     = 4;
    localparam int W           = 16;
    localparam int ID_W        = 2;
    localparam int TB_MAX_ITER = 20;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ*W-1:0] req_a     = '0;
    logic [NUM_REQ*W-1:0] req_b     = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [ID_W-1:0]      rsp_id;
    logic [W-1:0]         rsp_gcd;
    logic                 rsp_err;
    logic [W-1:0]         dp_data_in;
    logic                 dp_ldA, dp_ldB, dp_sel1, dp_sel2, dp_selin;
    logic                 dp_lt, dp_gt, dp_eq;
    logic [W-1:0]         dp_aout;

    gcd_sched #(
        .NUM_REQ  (NUM_REQ),
        .W        (W),
        .ID_W     (ID_W),
        .MAX_ITER (TB_MAX_ITER)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_gcd    (rsp_gcd),
        .rsp_err    (rsp_err),
        .dp_data_in (dp_data_in),
        .dp_ldA     (dp_ldA),
        .dp_ldB     (dp_ldB),
        .dp_sel1    (dp_sel1),
        .dp_sel2    (dp_sel2),
        .dp_selin   (dp_selin),
        .dp_lt      (dp_lt),
        .dp_gt      (dp_gt),
        .dp_eq      (dp_eq),
        .dp_aout    (dp_aout)
    );

    always #5 clk = ~clk;

    // Shared GCD datapath: A/B registers, operand muxes, subtractor, comparator
    logic [W-1:0] dpa = '0;
    logic [W-1:0] dpb = '0;
    logic [W-1:0] dp_diff, dp_next;
    assign dp_diff = (dp_sel1 ? dpb : dpa) - (dp_sel2 ? dpb : dpa);
    assign dp_next = dp_selin ? dp_data_in : dp_diff;
    always @(posedge clk) begin
        if (dp_ldA) dpa <= dp_next;
        if (dp_ldB) dpb <= dp_next;
    end
    assign dp_lt   = (dpa < dpb);
    assign dp_gt   = (dpa > dpb);
    assign dp_eq   = (dpa == dpb);
    assign dp_aout = dpa;

    logic [63:0] all_out;
    assign all_out = 64'({req_ready, rsp_valid, rsp_id, rsp_gcd, rsp_err,
                          dp_data_in, dp_ldA, dp_ldB, dp_sel1, dp_sel2, dp_selin});

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: Euclid by repeated subtraction with the iteration cap
    function automatic void ref_gcd(input int a, input int b,
                                    output int g, output bit err, output int lat);
        int x = a;
        int y = b;
        int k = 0;
        if (a == 0 || b == 0) begin
            g = a | b; err = 1'b0; lat = 1;
            return;
        end
        while (x != y && k < TB_MAX_ITER) begin
            if (x > y) x = x - y;
            else       y = y - x;
            k++;
        end
        err = (x != y);
        g   = x;
        lat = err ? 4 + TB_MAX_ITER : 4 + k;
    endfunction

    typedef struct {
        int id;
        int g;
        bit err;
        int t;
        int gc;
    } exp_t;

    exp_t q[$];
    int   dut_glog[$];
    int   cyc = 0;
    int   grant_cnt [NUM_REQ];
    int   seen_cnt  [NUM_REQ];
    bit   busy = 1'b0;
    int   ptr  = NUM_REQ - 1;
    bit   head_seen = 1'b0;
    logic pv = 1'b0, pr = 1'b0;
    logic [63:0] pkeep = '0;
    int   last_id, last_g, last_lat;
    bit   last_err;
    bit   rand_mode  = 1'b0;
    bit   keep_valid = 1'b0;

    int   m_g, m_j, m_lat, m_gcd;
    bit   m_err;
    logic [NUM_REQ-1:0] m_exp_rdy;
    exp_t m_e;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i] = 0;
            seen_cnt[i]  = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            busy      = 1'b0;
            ptr       = NUM_REQ - 1;
            head_seen = 1'b0;
            pv        = 1'b0;
            pr        = 1'b0;
        end else begin
            m_g = -1;
            if (!busy) begin
                for (int o = 1; o <= NUM_REQ; o++) begin
                    m_j = (ptr + o) % NUM_REQ;
                    if (m_g < 0 && req_valid[m_j]) m_g = m_j;
                end
            end
            m_exp_rdy = '0;
            if (m_g >= 0) m_exp_rdy[m_g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(m_exp_rdy));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) dut_glog.push_back(i);
            end
            if (m_g >= 0) begin
                ref_gcd(int'(req_a[m_g*W +: W]), int'(req_b[m_g*W +: W]), m_gcd, m_err, m_lat);
                m_e.id = m_g; m_e.g = m_gcd; m_e.err = m_err;
                m_e.t = cyc + m_lat; m_e.gc = cyc;
                q.push_back(m_e);
                busy = 1'b1;
                ptr  = m_g;
                grant_cnt[m_g]++;
            end

            if (q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                if (!head_seen) begin
                    if (cyc == q[0].t) begin
                        chk("rsp_latency", 64'(rsp_valid), 64'd1);
                        head_seen = 1'b1;
                        last_lat  = cyc - q[0].gc;
                    end else if (rsp_valid) begin
                        chk("rsp_early_cycle", 64'(cyc), 64'(q[0].t));
                        head_seen = 1'b1;
                        last_lat  = cyc - q[0].gc;
                    end
                end
                if (rsp_valid && pv && !pr) begin
                    chk("rsp_stable", 64'({rsp_id, rsp_gcd, rsp_err}), pkeep);
                end
                if (rsp_valid) begin
                    chk("dp_idle_in_resp", 64'({dp_data_in, dp_ldA, dp_ldB, dp_sel1, dp_sel2, dp_selin}), 64'd0);
                end
                if (rsp_valid && rsp_ready) begin
                    chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
                    chk("rsp_err", 64'(rsp_err), 64'(q[0].err));
                    if (!q[0].err) chk("rsp_gcd", 64'(rsp_gcd), 64'(q[0].g));
                    last_id = rsp_id; last_g = rsp_gcd; last_err = rsp_err;
                    void'(q.pop_front());
                    busy      = 1'b0;
                    head_seen = 1'b0;
                end else if (head_seen && !rsp_valid) begin
                    void'(q.pop_front());
                    busy      = 1'b0;
                    head_seen = 1'b0;
                end
            end
            chk("ld_exclusive", 64'(dp_ldA & dp_ldB), 64'd0);
            pv    = rsp_valid;
            pr    = rsp_ready;
            pkeep = 64'({rsp_id, rsp_gcd, rsp_err});
        end
    end

    function automatic logic [W-1:0] rnd_op();
        if ($urandom_range(0, 7) == 0) return '0;
        return W'($urandom_range(1, 40));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_cnt[i] != seen_cnt[i]) begin
                seen_cnt[i] = grant_cnt[i];
                if (!keep_valid) req_valid[i] = 1'b0;
            end
            if (rand_mode && !req_valid[i]) begin
                req_a[i*W +: W] = rnd_op();
                req_b[i*W +: W] = rnd_op();
                if ($urandom_range(0, 3) == 0) req_valid[i] = 1'b1;
            end
        end
        if (rand_mode) rsp_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic wait_grant(input int id, input int g0);
        int n = 0;
        while (grant_cnt[id] == g0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("grant_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || req_valid != '0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic raise(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid[id]    = 1'b1;
    endtask

    task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        int g0 = grant_cnt[id];
        raise(id, a, b);
        wait_grant(id, g0);
        drain();
    endtask

    typedef struct {
        int id; int a; int b; int g; bit err; int lat;
    } dir_t;

    dir_t dir_tab[8] = '{
        '{0, 48,  18, 6, 1'b0, 8},
        '{1, 7,   7,  7, 1'b0, 4},
        '{2, 0,   9,  9, 1'b0, 1},
        '{3, 0,   0,  0, 1'b0, 1},
        '{0, 100, 1,  0, 1'b1, 24},
        '{1, 9,   3,  3, 1'b0, 6},
        '{2, 21,  1,  1, 1'b0, 24},
        '{3, 22,  1,  0, 1'b1, 24}
    };

    int rr_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int total;
        #1 rst_n = 1'b0;
        #2 chk("reset_outputs", all_out, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // All four requesters held valid from reset
        dut_glog.delete();
        keep_valid = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) raise(i, 16'd12, 16'd8);
        n = 0;
        while (dut_glog.size() < 5 && n < 300) begin
            tick();
            n++;
        end
        req_valid  = '0;
        keep_valid = 1'b0;
        chk("rr_grant_count", 64'(dut_glog.size() >= 5), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < dut_glog.size()) chk("rr_order", 64'(dut_glog[i]), 64'(rr_exp[i]));
        end
        drain();

        foreach (dir_tab[i]) begin
            send(dir_tab[i].id, W'(dir_tab[i].a), W'(dir_tab[i].b));
            chk("dir_id", 64'(last_id), 64'(dir_tab[i].id));
            chk("dir_err", 64'(last_err), 64'(dir_tab[i].err));
            chk("dir_latency", 64'(last_lat), 64'(dir_tab[i].lat));
            if (!dir_tab[i].err) chk("dir_gcd", 64'(last_g), 64'(dir_tab[i].g));
        end

        // Response back-pressure with other requesters waiting
        rsp_ready = 1'b0;
        base = grant_cnt[1];
        raise(1, 16'd12, 16'd8);
        wait_grant(1, base);
        raise(2, 16'd30, 16'd12);
        raise(3, 16'd5, 16'd0);
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk("stall_rsp_seen", 64'(rsp_valid), 64'd1);
        repeat (10) tick();
        rsp_ready = 1'b1;
        drain();

        // Reset in the middle of a long iteration
        base = grant_cnt[2];
        raise(2, 16'hFFFF, 16'd1);
        wait_grant(2, base);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_iter", all_out, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        base = dut_glog.size();
        for (int i = 0; i < NUM_REQ; i++) raise(i, W'(6 + i), 16'd4);
        n = 0;
        while (dut_glog.size() == base && n < 50) begin
            tick();
            n++;
        end
        if (dut_glog.size() > base) chk("post_reset_grant", 64'(dut_glog[base]), 64'd0);
        else                        chk("post_reset_grant_seen", 64'd0, 64'd1);
        drain();

        // Randomized traffic with random response back-pressure
        rand_mode = 1'b1;
        n = 0;
        total = 0;
        while (total < 150 && n < 20000) begin
            tick();
            n++;
            total = 0;
            for (int i = 0; i < NUM_REQ; i++) total += grant_cnt[i];
        end
        rand_mode = 1'b0;
        rsp_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
